seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU; generic WIDTH replaces the fixed 16-bit datapath.
- Keeps all single-cycle operations and adds iterative unsigned multiply (shift-add) and unsigned divide (restoring), with a start/done handshake.
- Operand muxing stays outside this block: the control unit drives a and b directly.
- Result is registered internally, replacing the external output register.

Parameters:
- WIDTH, 16, datapath width in bits (>= 4).
- SHW, $clog2(WIDTH), shift-amount bits taken from b (derived, not overridden).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  4  operation code, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  out  WIDTH  primary result (product low half or quotient).
- result_hi  out  WIDTH  product high half or remainder; 0 for other ops.
- overflow  out  1  signed add/sub overflow; for mul, result_hi != 0.
- zero  out  1  result == 0 (registered with result).
- div_by_zero  out  1  divide attempted with b == 0.
- illegal_op  out  1  op not in the encoding list.

Behaviour:
- Opcodes:
  - 0000 and; 0001 or; 0010 add; 0011 sub.
  - 0100 slt (signed); 0101 sgt (signed); 0110 seq.
  - 1000 shl; 1001 shr logical; 1010 sra arithmetic.
  - 1011 mul; 1100 divu.
  - All other codes are illegal.
- State machine IDLE -> RUN -> DONE -> IDLE. busy = (state != IDLE).
- start with busy=0:
  - Latches op, a, b.
  - Single-cycle ops, illegal ops and divide-by-zero go directly to DONE.
  - mul/divu go to RUN with an iteration counter loaded to WIDTH-1.
- RUN: one partial-product or restoring step per cycle. The counter decrements; at 0 the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - Single-cycle op: done in the cycle after the start edge (1 cycle).
  - mul/divu: done WIDTH+1 cycles after the start edge.
  - Maximum issue rate: one single-cycle op every 2 cycles.
- start while busy=1: ignored, with no effect on the latched operands or in-flight state.
- Outputs hold their last values until the next done. Flags update only together with result at done.
- Comparison ops: result = {WIDTH-1 zeros, bit}.
  - slt/sgt use a true signed comparison, not the sign of the difference, so they are correct when a-b overflows.
  - sgt = !slt && !seq.
- Shifts:
  - Amount = b[SHW-1:0] when b < WIDTH.
  - If b >= WIDTH: shl/shr give 0; sra gives WIDTH copies of a[WIDTH-1].
- add/sub: overflow = signed overflow (operand signs equal for add, operand signs differ for sub, and result sign differs from a). Other single-cycle ops: overflow=0.
- mul: unsigned WIDTH x WIDTH, giving the 2*WIDTH product {result_hi, result}.
- divu: result = quotient, result_hi = remainder.
- divu with b==0: result = all ones, result_hi = a, div_by_zero=1, overflow=0.
- Illegal op: result=0, result_hi=0, illegal_op=1, zero=1.
- div_by_zero and illegal_op are cleared at the done of any later operation.
- Reset asserted (low), at any time including mid-RUN:
  - State goes to IDLE and the operation is abandoned.
  - busy, done, result, result_hi, overflow, zero, div_by_zero and illegal_op all go to 0.
  - After release, the first start is accepted normally.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams (OP_AND .. OP_DIVU).
  - State enum type (S_IDLE, S_RUN, S_DONE).
  - Opcode-classification function is_multicycle(op).
- One natural sub-module, seq_alu_iter: the shared mul/div iteration engine.
  - Holds the accumulator, shift register and counter.
  - Interface: load, mode, step, finished.
  - The top level keeps the FSM and the combinational single-cycle ops.

Test Plan:
- WIDTH=16, add a=16'h7FFF, b=16'h0001 -> done 1 cycle after start, result=16'h8000, overflow=1, zero=0.
- slt a=16'h8000, b=16'h7FFF -> result=1. sgt on the same operands -> 0. seq a=b=16'h1234 -> result=1.
- mul a=16'h1234, b=16'h0100 -> done 17 cycles after start, result=16'h3400, result_hi=16'h0012, overflow=1. mul a=3, b=5 -> result 15, overflow=0.
- divu a=100, b=7 -> result=14, result_hi=2 after 17 cycles. divu a=5, b=0 -> 1-cycle latency, result=16'hFFFF, result_hi=5, div_by_zero=1.
- sra a=16'h8000, b=20 -> result=16'hFFFF. shl with b=16 -> 0. op=4'b1111 -> illegal_op=1, result=0.
- Reset low at RUN cycle 5 of a mul -> all outputs 0 and busy=0 immediately. A start held high during busy is ignored. A fresh add after reset release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode helpers
// for the sequential ALU and its iteration engine.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SGT  = 4'b0101;
  localparam logic [3:0] OP_SEQ  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_multicycle(
    input logic [3:0] op
  );
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared shift-add multiply / restoring divide engine.
// Ports: load/mode/a/b start an op, step advances one bit,
// finished flags the last step, lo_nx/hi_nx are step results.
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             finished,
  output logic [WIDTH-1:0] lo_nx,
  output logic [WIDTH-1:0] hi_nx
);

  localparam logic [SHW-1:0] CNT_INIT =
    SHW'(WIDTH - 1);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // mode 0: {acc,mq} shifts right, acc gathers the
  // product. mode 1: {acc,mq} shifts left, acc is the
  // partial remainder and mq collects quotient bits.
  always_comb begin
    sum   = {1'b0, acc_q}
          + (mq_q[0] ? {1'b0, b_q} : '0);
    sh    = {acc_q, mq_q[WIDTH-1]};
    ge    = sh >= {1'b0, b_q};
    diff  = sh[WIDTH-1:0] - b_q;
    lo_nx = '0;
    hi_nx = '0;
    if (mode_q) begin
      hi_nx = ge ? diff : sh[WIDTH-1:0];
      lo_nx = {mq_q[WIDTH-2:0], ge};
    end else begin
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], mq_q[WIDTH-1:1]};
    end
  end

  assign finished = (cnt_q == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      mq_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      acc_q  <= '0;
      mq_q   <= a;
      b_q    <= b;
      mode_q <= mode;
      cnt_q  <= CNT_INIT;
    end else if (step) begin
      acc_q  <= hi_nx;
      mq_q   <= lo_nx;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift
// plus iterative mul/divu, start/done handshake, registered results.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);

  state_e           state_q;
  logic [3:0]       op_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic             ovf_q;
  logic             zero_q;
  logic             dbz_q;
  logic             ill_q;

  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [SHW-1:0]   amt;
  logic             b_big;
  logic             lt;
  logic             eq;
  logic             dz;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ovf;
  logic             sc_dbz;
  logic             sc_ill;

  logic             it_load;
  logic             it_step;
  logic             it_fin;
  logic [WIDTH-1:0] it_lo;
  logic [WIDTH-1:0] it_hi;

  assign add_r = a + b;
  assign sub_r = a - b;
  assign amt   = b[SHW-1:0];
  assign b_big = b >= WV;
  assign lt    = $signed(a) < $signed(b);
  assign eq    = a == b;
  assign dz    = (op == OP_DIVU) && (b == '0);

  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    unique case (op)
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_ADD: begin
        sc_res = add_r;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1])
              && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_r;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1])
              && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, lt};
      OP_SGT: sc_res = {{(WIDTH-1){1'b0}}, !lt && !eq};
      OP_SEQ: sc_res = {{(WIDTH-1){1'b0}}, eq};
      OP_SHL: sc_res = b_big ? '0 : a << amt;
      OP_SHR: sc_res = b_big ? '0 : a >> amt;
      OP_SRA: sc_res = b_big ? {WIDTH{a[WIDTH-1]}}
                             : WIDTH'($signed(a) >>> amt);
      OP_MUL: sc_res = '0;
      OP_DIVU: begin
        // Only reached here when b == 0.
        sc_res = '1;
        sc_hi  = a;
        sc_dbz = 1'b1;
      end
      default: sc_ill = 1'b1;
    endcase
  end

  assign it_load = (state_q == S_IDLE) && start
                && is_multicycle(op) && !dz;
  assign it_step = (state_q == S_RUN);

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clock    (clock),
    .reset    (reset),
    .load     (it_load),
    .mode     (op == OP_DIVU),
    .a        (a),
    .b        (b),
    .step     (it_step),
    .finished (it_fin),
    .lo_nx    (it_lo),
    .hi_nx    (it_hi)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q <= op;
            if (it_load) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              res_q   <= sc_res;
              hi_q    <= sc_hi;
              ovf_q   <= sc_ovf;
              zero_q  <= (sc_res == '0);
              dbz_q   <= sc_dbz;
              ill_q   <= sc_ill;
            end
          end
        end
        S_RUN: begin
          // Last step: capture the engine's step output
          // directly so done lands on the same edge.
          if (it_fin) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            res_q   <= it_lo;
            hi_q    <= it_hi;
            ovf_q   <= (op_q == OP_MUL) && (it_hi != '0);
            zero_q  <= (it_lo == '0);
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = res_q;
  assign result_hi   = hi_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed table-driven bench for seq_alu (WIDTH=16)
// plus reset-abort and start-while-busy sequences.
module tb_seq_alu;

  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         overflow;
  logic         zero;
  logic         div_by_zero;
  logic         illegal_op;

  int n_chk;
  int n_fail;

  seq_alu #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_hi   (result_hi),
    .overflow    (overflow),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ovf;
    logic         zr;
    logic         dbz;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t vt[20];

  task automatic check(
    input string name,
    input int    act,
    input int    exp
  );
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Issue one op; returns cycles from start edge to done
  // (1 = done right after the start edge).
  task automatic run_op(
    input  logic [3:0]   o,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output int           lat
  );
    @(posedge clock); #1;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic check_idle_after(input string name);
    @(posedge clock); #1;
    check({name, "_done_pulse"}, int'(done), 0);
    check({name, "_busy_end"}, int'(busy), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_res"}, int'(result), 0);
    check({name, "_hi"}, int'(result_hi), 0);
    check({name, "_ovf"}, int'(overflow), 0);
    check({name, "_zero"}, int'(zero), 0);
    check({name, "_dbz"}, int'(div_by_zero), 0);
    check({name, "_ill"}, int'(illegal_op), 0);
  endtask

  initial begin
    int lat;
    string nm;
    n_chk  = 0;
    n_fail = 0;

    //        op     a        b        res      hi       ov zr dz il lat
    vt[0]  = '{4'h2, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1, 0, 0, 0, 1};
    vt[1]  = '{4'h4, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000, 0, 0, 0, 0, 1};
    vt[2]  = '{4'h5, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 0, 1, 0, 0, 1};
    vt[3]  = '{4'h6, 16'h1234, 16'h1234, 16'h0001, 16'h0000, 0, 0, 0, 0, 1};
    vt[4]  = '{4'hB, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1, 0, 0, 0, 17};
    vt[5]  = '{4'hB, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 0, 0, 0, 0, 17};
    vt[6]  = '{4'hC, 16'd100,  16'd7,    16'd14,   16'd2,    0, 0, 0, 0, 17};
    vt[7]  = '{4'hC, 16'd5,    16'd0,    16'hFFFF, 16'd5,    0, 0, 1, 0, 1};
    vt[8]  = '{4'hA, 16'h8000, 16'd20,   16'hFFFF, 16'h0000, 0, 0, 0, 0, 1};
    vt[9]  = '{4'h8, 16'h1234, 16'd16,   16'h0000, 16'h0000, 0, 1, 0, 0, 1};
    vt[10] = '{4'hF, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 0, 1, 0, 1, 1};
    vt[11] = '{4'h0, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 0, 0, 0, 0, 1};
    vt[12] = '{4'h3, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1, 0, 0, 0, 1};
    vt[13] = '{4'h9, 16'h8000, 16'd4,    16'h0800, 16'h0000, 0, 0, 0, 0, 1};
    vt[14] = '{4'hA, 16'h8000, 16'd4,    16'hF800, 16'h0000, 0, 0, 0, 0, 1};
    vt[15] = '{4'h1, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 0, 0, 0, 0, 1};
    vt[16] = '{4'h3, 16'd5,    16'd5,    16'h0000, 16'h0000, 0, 1, 0, 0, 1};
    vt[17] = '{4'h4, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 0, 1, 0, 0, 1};
    vt[18] = '{4'hC, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0, 0, 17};
    vt[19] = '{4'h7, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 0, 1, 0, 1, 1};

    reset = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    foreach (vt[i]) begin
      nm = $sformatf("v%0d", i);
      run_op(vt[i].op, vt[i].a, vt[i].b, lat);
      check({nm, "_lat"}, lat, vt[i].lat);
      check({nm, "_res"}, int'(result), int'(vt[i].res));
      check({nm, "_hi"}, int'(result_hi), int'(vt[i].hi));
      check({nm, "_ovf"}, int'(overflow), int'(vt[i].ovf));
      check({nm, "_zero"}, int'(zero), int'(vt[i].zr));
      check({nm, "_dbz"}, int'(div_by_zero), int'(vt[i].dbz));
      check({nm, "_ill"}, int'(illegal_op), int'(vt[i].ill));
      check_idle_after(nm);
    end

    // start held high through a mul: later requests ignored
    @(posedge clock); #1;
    start = 1'b1;
    op = 4'hB;
    a = 16'd3;
    b = 16'd5;
    @(posedge clock); #1;
    op = 4'h2;
    a = 16'd1;
    b = 16'd1;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    check("held_lat", lat, 17);
    check("held_res", int'(result), 15);
    check("held_hi", int'(result_hi), 0);
    check_idle_after("held");

    // nonzero outputs, then reset mid-RUN of a mul
    run_op(4'h2, 16'h7FFF, 16'h0001, lat);
    @(posedge clock); #1;
    start = 1'b1;
    op = 4'hB;
    a = 16'h1234;
    b = 16'h0100;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_busy", int'(busy), 1);
    check("mid_res_prev", int'(result), 16'h8000);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clock); #1;
    check("abort_held_busy", int'(busy), 0);
    reset = 1'b1;

    run_op(4'h2, 16'd2, 16'd3, lat);
    check("post_lat", lat, 1);
    check("post_res", int'(result), 5);
    check("post_ovf", int'(overflow), 0);
    check_idle_after("post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
